// File: rtl/rx_buf_rd_arb.sv
// ---------------------------------------------------------------------------
// tcp_pkg: shared widths for the RX payload buffer datapath.
// ---------------------------------------------------------------------------
package tcp_pkg;
  localparam int FLOWID_W         = 8;
  localparam int RX_PAYLOAD_IDX_W = 6;
  localparam int TCP_BUF_W        = 32;
endpackage

// ---------------------------------------------------------------------------
// rx_buf_rd_arb
//   Round-robin arbiter sharing the RX payload buffer store's rd0 port among
//   NUM_REQ requesters. One request is forwarded per cycle with no added
//   latency. The grant ID of every forwarded request goes into an in-order
//   tag FIFO, and each returning buffer is steered to the requester at the
//   head of that FIFO (the store answers in request order).
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   src_req_*       per-requester read requests (flattened flowid/idx)
//   src_resp_*      per-requester response valid/ready, shared data bus
//   mem_req_*       read request toward the store
//   mem_resp_*      response from the store
//   orphan_err      sticky: store responded with nothing outstanding
// ---------------------------------------------------------------------------
module rx_buf_rd_arb
  import tcp_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = 4,
  localparam int REQ_ID_W = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  src_req_val,
  input  logic [NUM_REQ*FLOWID_W-1:0]         src_req_flowid,
  input  logic [NUM_REQ*RX_PAYLOAD_IDX_W-1:0] src_req_idx,
  output logic [NUM_REQ-1:0]                  src_req_rdy,
  output logic [NUM_REQ-1:0]                  src_resp_val,
  output logic [TCP_BUF_W-1:0]                src_resp_data,
  input  logic [NUM_REQ-1:0]                  src_resp_rdy,
  output logic                                mem_req_val,
  output logic [FLOWID_W-1:0]                 mem_req_flowid,
  output logic [RX_PAYLOAD_IDX_W-1:0]         mem_req_idx,
  input  logic                                mem_req_rdy,
  input  logic                                mem_resp_val,
  input  logic [TCP_BUF_W-1:0]                mem_resp_data,
  output logic                                mem_resp_rdy,
  output logic                                orphan_err
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam int SUM_W = REQ_ID_W + 1;

  // Arbitration state
  logic                rr_ptr_r_dummy_unused;
  logic [REQ_ID_W-1:0] rr_ptr_r;
  logic                lock_val_r;
  logic [REQ_ID_W-1:0] lock_id_r;

  // Tag FIFO state
  logic [REQ_ID_W-1:0] tag_mem_r [TAG_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                orphan_err_r;

  // Combinational decode
  logic                grant_val_s;
  logic [REQ_ID_W-1:0] grant_id_s;
  logic [REQ_ID_W-1:0] cand_s;
  logic [SUM_W-1:0]    sum_s;
  logic [REQ_ID_W-1:0] rr_next_s;
  logic                tag_full_s;
  logic                empty_s;
  logic [REQ_ID_W-1:0] head_s;
  logic                req_hs_s;
  logic                resp_hs_s;
  logic                resp_live_s;

  assign rr_ptr_r_dummy_unused = 1'b0;

  // Wrap a tag FIFO pointer at TAG_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(TAG_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign tag_full_s = (count_r == CNT_W'(TAG_DEPTH));
  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign head_s     = tag_mem_r[rd_ptr_r];

  // Grant selection: a locked grant wins, otherwise first valid from rr_ptr.
  always_comb begin
    grant_val_s = 1'b0;
    grant_id_s  = {REQ_ID_W{1'b0}};
    cand_s      = {REQ_ID_W{1'b0}};
    sum_s       = {SUM_W{1'b0}};
    if (lock_val_r) begin
      grant_val_s = 1'b1;
      grant_id_s  = lock_id_r;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum_s = {1'b0, rr_ptr_r} + SUM_W'(k);
        if (sum_s >= SUM_W'(NUM_REQ)) begin
          sum_s = sum_s - SUM_W'(NUM_REQ);
        end else begin
          sum_s = sum_s;
        end
        cand_s = sum_s[REQ_ID_W-1:0];
        if (!grant_val_s && src_req_val[cand_s]) begin
          grant_val_s = 1'b1;
          grant_id_s  = cand_s;
        end else begin
          grant_val_s = grant_val_s;
        end
      end
    end
  end

  // Next round-robin start point: one past the current grant.
  always_comb begin
    if (grant_id_s == REQ_ID_W'(NUM_REQ - 1)) begin
      rr_next_s = {REQ_ID_W{1'b0}};
    end else begin
      rr_next_s = grant_id_s + REQ_ID_W'(1);
    end
  end

  // Request path toward the store; all val/rdy are held low while in reset.
  always_comb begin
    mem_req_val    = grant_val_s & ~tag_full_s & ~rst;
    mem_req_flowid = src_req_flowid[grant_id_s*FLOWID_W +: FLOWID_W];
    mem_req_idx    = src_req_idx[grant_id_s*RX_PAYLOAD_IDX_W +: RX_PAYLOAD_IDX_W];
    src_req_rdy    = {NUM_REQ{1'b0}};
    src_req_rdy[grant_id_s] = grant_val_s & mem_req_rdy & ~tag_full_s & ~rst;
  end

  assign req_hs_s = mem_req_val & mem_req_rdy;

  // Response routing: only the requester at the tag FIFO head sees the data.
  always_comb begin
    resp_live_s   = mem_resp_val & ~empty_s & ~rst;
    src_resp_data = mem_resp_data;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_resp_val[i] = resp_live_s & (head_s == REQ_ID_W'(i));
    end
    mem_resp_rdy = src_resp_rdy[head_s] & ~empty_s & ~rst;
  end

  assign resp_hs_s  = mem_resp_val & mem_resp_rdy;
  assign orphan_err = orphan_err_r;

  // Round-robin pointer and grant lock held while the store stalls a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r   <= {REQ_ID_W{1'b0}};
      lock_val_r <= 1'b0;
      lock_id_r  <= {REQ_ID_W{1'b0}};
    end else if (req_hs_s) begin
      rr_ptr_r   <= rr_next_s;
      lock_val_r <= 1'b0;
    end else if (mem_req_val && !mem_req_rdy) begin
      lock_val_r <= 1'b1;
      lock_id_r  <= grant_id_s;
    end
  end

  // Tag FIFO storage and pointers: push on request, pop on response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_r[i] <= {REQ_ID_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (req_hs_s) begin
        tag_mem_r[wr_ptr_r] <= grant_id_s;
        wr_ptr_r            <= ptr_inc(wr_ptr_r);
      end
      if (resp_hs_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({req_hs_s, resp_hs_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for a store response with no outstanding tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orphan_err_r <= 1'b0;
    end else if (mem_resp_val && empty_s) begin
      orphan_err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_buf_rd_arb.sv
module tb_rx_buf_rd_arb;
  import tcp_pkg::*;

  localparam int NR = 2;

  logic                          clk;
  logic                          rst;
  logic [NR-1:0]                 req_val;
  logic [NR*FLOWID_W-1:0]        req_flowid;
  logic [NR*RX_PAYLOAD_IDX_W-1:0] req_idx;
  logic [NR-1:0]                 src_req_rdy;
  logic [NR-1:0]                 src_resp_val;
  logic [TCP_BUF_W-1:0]          src_resp_data;
  logic [NR-1:0]                 resp_rdy;
  logic                          mem_req_val;
  logic [FLOWID_W-1:0]           mem_req_flowid;
  logic [RX_PAYLOAD_IDX_W-1:0]   mem_req_idx;
  logic                          mem_req_rdy;
  logic                          mem_resp_val;
  logic [TCP_BUF_W-1:0]          mem_resp_data;
  logic                          mem_resp_rdy;
  logic                          orphan_err;

  rx_buf_rd_arb #(.NUM_REQ(NR), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .src_req_val(req_val), .src_req_flowid(req_flowid), .src_req_idx(req_idx),
    .src_req_rdy(src_req_rdy),
    .src_resp_val(src_resp_val), .src_resp_data(src_resp_data), .src_resp_rdy(resp_rdy),
    .mem_req_val(mem_req_val), .mem_req_flowid(mem_req_flowid), .mem_req_idx(mem_req_idx),
    .mem_req_rdy(mem_req_rdy),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data), .mem_resp_rdy(mem_resp_rdy),
    .orphan_err(orphan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                   req;
    logic [TCP_BUF_W-1:0] data;
  } exp_t;

  exp_t                 exp_q[$];
  logic [TCP_BUF_W-1:0] store_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  // Store contents: a fixed function of the address.
  function automatic logic [TCP_BUF_W-1:0] data_of(input logic [FLOWID_W-1:0] f,
                                                   input logic [RX_PAYLOAD_IDX_W-1:0] ix);
    return {f, 2'b10, ix, 16'h00AB};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [FLOWID_W-1:0] f,
                         input logic [RX_PAYLOAD_IDX_W-1:0] ix);
    req_val[i] = v;
    req_flowid[i*FLOWID_W +: FLOWID_W] = f;
    req_idx[i*RX_PAYLOAD_IDX_W +: RX_PAYLOAD_IDX_W] = ix;
  endtask

  // Store model drives its oldest pending response.
  task automatic resp_drive(input logic v);
    mem_resp_val  = v;
    mem_resp_data = (store_q.size() != 0) ? store_q[0] : 32'hDEAD_BEEF;
  endtask

  // Record handshakes about to happen, check routed responses, then advance.
  task automatic tick();
    exp_t e;
    if (mem_resp_val && mem_resp_rdy) begin
      chk("resp_has_owner", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("resp_route", 64'(src_resp_val), 64'd1 << e.req);
        chk("resp_data", 64'(src_resp_data), 64'(e.data));
      end
      if (store_q.size() != 0) void'(store_q.pop_front());
    end
    if (mem_req_val && mem_req_rdy) store_q.push_back(data_of(mem_req_flowid, mem_req_idx));
    for (int i = 0; i < NR; i++) begin
      if (req_val[i] && src_req_rdy[i]) begin
        e.req  = i;
        e.data = data_of(req_flowid[i*FLOWID_W +: FLOWID_W],
                         req_idx[i*RX_PAYLOAD_IDX_W +: RX_PAYLOAD_IDX_W]);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with active inputs: outputs must stay low.
    rst = 1'b1;
    req_val = 2'b11; req_flowid = '0; req_idx = '0;
    resp_rdy = 2'b11; mem_req_rdy = 1'b1;
    resp_drive(1'b1);
    @(negedge clk); #1;
    chk("rst_mem_req_val", 64'(mem_req_val), 64'd0);
    chk("rst_src_req_rdy", 64'(src_req_rdy), 64'd0);
    chk("rst_src_resp_val", 64'(src_resp_val), 64'd0);
    chk("rst_mem_resp_rdy", 64'(mem_resp_rdy), 64'd0);
    chk("rst_orphan", 64'(orphan_err), 64'd0);
    chk("rst_count", 64'(dut.count_r), 64'd0);
    @(negedge clk);
    rst = 1'b0; req_val = 2'b00; resp_drive(1'b0);

    // Single requester: src 1 reads flowid 3 idx 5.
    set_req(1, 1'b1, 8'd3, 6'd5); #1;
    chk("single_val", 64'(mem_req_val), 64'd1);
    chk("single_flowid", 64'(mem_req_flowid), 64'd3);
    chk("single_idx", 64'(mem_req_idx), 64'd5);
    chk("single_rdy", 64'(src_req_rdy), 64'b10);
    tick();
    set_req(1, 1'b0, 8'd3, 6'd5); #1;
    chk("single_count1", 64'(dut.count_r), 64'd1);
    tick();
    resp_drive(1'b1); #1;
    chk("single_resp_val", 64'(src_resp_val), 64'b10);
    chk("single_mem_resp_rdy", 64'(mem_resp_rdy), 64'd1);
    tick();
    resp_drive(1'b0); #1;
    chk("single_count0", 64'(dut.count_r), 64'd0);

    // Round robin: both requesters hold val for 6 cycles.
    set_req(0, 1'b1, 8'd7, 6'd1);
    set_req(1, 1'b1, 8'd9, 6'd2);
    for (int k = 0; k < 6; k++) begin
      resp_drive(store_q.size() != 0); #1;
      chk("rr_flowid", 64'(mem_req_flowid), (k % 2 == 0) ? 64'd7 : 64'd9);
      chk("rr_rdy", 64'(src_req_rdy), (k % 2 == 0) ? 64'b01 : 64'b10);
      tick();
    end
    req_val = 2'b00;
    resp_drive(1'b1); #1;
    tick();
    resp_drive(1'b0); #1;
    chk("rr_count0", 64'(dut.count_r), 64'd0);
    chk("rr_sb_empty", 64'(exp_q.size()), 64'd0);

    // Lock under backpressure: src 1 stalled, src 0 arrives meanwhile.
    mem_req_rdy = 1'b0;
    set_req(1, 1'b1, 8'd21, 6'd3); #1;
    chk("lock_val", 64'(mem_req_val), 64'd1);
    chk("lock_flowid0", 64'(mem_req_flowid), 64'd21);
    chk("lock_rdy0", 64'(src_req_rdy), 64'd0);
    tick();
    set_req(0, 1'b1, 8'd20, 6'd4);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("lock_flowid", 64'(mem_req_flowid), 64'd21);
      chk("lock_idx", 64'(mem_req_idx), 64'd3);
      chk("lock_rdy", 64'(src_req_rdy), 64'd0);
      tick();
    end
    mem_req_rdy = 1'b1; #1;
    chk("lock_accept_flowid", 64'(mem_req_flowid), 64'd21);
    chk("lock_accept_rdy", 64'(src_req_rdy), 64'b10);
    tick();
    set_req(1, 1'b0, 8'd21, 6'd3); #1;
    chk("lock_next_flowid", 64'(mem_req_flowid), 64'd20);
    chk("lock_next_rdy", 64'(src_req_rdy), 64'b01);
    tick();
    set_req(0, 1'b0, 8'd20, 6'd4);
    for (int c = 0; c < 2; c++) begin
      resp_drive(1'b1); #1;
      tick();
    end
    resp_drive(1'b0); #1;
    chk("lock_count0", 64'(dut.count_r), 64'd0);

    // Tag full: 4 accepted, 5th blocked until a pop, same-cycle pop no push.
    set_req(0, 1'b1, 8'd30, 6'd6);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("full_fill_rdy", 64'(src_req_rdy), 64'b01);
      tick();
    end
    #1;
    chk("full_count4", 64'(dut.count_r), 64'd4);
    chk("full_blk_rdy", 64'(src_req_rdy), 64'd0);
    chk("full_blk_val", 64'(mem_req_val), 64'd0);
    tick();
    #1;
    chk("full_blk_rdy2", 64'(src_req_rdy), 64'd0);
    resp_drive(1'b1); #1;
    chk("full_pop_rdy", 64'(src_req_rdy), 64'd0);
    chk("full_pop_count", 64'(dut.count_r), 64'd4);
    chk("full_pop_mem_rdy", 64'(mem_resp_rdy), 64'd1);
    tick();
    resp_drive(1'b0); #1;
    chk("full_after_pop", 64'(dut.count_r), 64'd3);
    chk("full_unblock_rdy", 64'(src_req_rdy), 64'b01);
    tick();
    #1;
    chk("full_refill", 64'(dut.count_r), 64'd4);
    set_req(0, 1'b0, 8'd30, 6'd6);
    for (int k = 0; k < 4; k++) begin
      resp_drive(1'b1); #1;
      tick();
    end
    resp_drive(1'b0); #1;
    chk("full_count0", 64'(dut.count_r), 64'd0);

    // Response backpressure from the head requester.
    set_req(0, 1'b1, 8'd40, 6'd7); #1;
    tick();
    set_req(0, 1'b0, 8'd40, 6'd7);
    set_req(1, 1'b1, 8'd41, 6'd8); #1;
    chk("bp_req_rdy", 64'(src_req_rdy), 64'b10);
    tick();
    set_req(1, 1'b0, 8'd41, 6'd8);
    resp_rdy = 2'b10;
    resp_drive(1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bp_count", 64'(dut.count_r), 64'd2);
      chk("bp_resp_val", 64'(src_resp_val), 64'b01);
      chk("bp_mem_rdy", 64'(mem_resp_rdy), 64'd0);
      tick();
    end
    resp_rdy = 2'b11; #1;
    chk("bp_release_rdy", 64'(mem_resp_rdy), 64'd1);
    tick();
    resp_drive(1'b1); #1;
    chk("bp_count1", 64'(dut.count_r), 64'd1);
    tick();
    resp_drive(1'b0); #1;
    chk("bp_count0", 64'(dut.count_r), 64'd0);

    // Orphan response with empty FIFO.
    resp_drive(1'b1); #1;
    chk("orph_mem_rdy", 64'(mem_resp_rdy), 64'd0);
    chk("orph_resp_val", 64'(src_resp_val), 64'd0);
    chk("orph_pre", 64'(orphan_err), 64'd0);
    tick();
    resp_drive(1'b0); #1;
    chk("orph_set", 64'(orphan_err), 64'd1);
    tick();
    #1;
    chk("orph_sticky", 64'(orphan_err), 64'd1);

    // Asynchronous reset with two tags outstanding.
    set_req(0, 1'b1, 8'd50, 6'd9); #1;
    tick();
    #1;
    tick();
    #1;
    chk("rst_pre_count", 64'(dut.count_r), 64'd2);
    resp_drive(1'b1);
    #1;
    rst = 1'b1;
    store_q.delete();
    exp_q.delete();
    #1;
    chk("arst_count", 64'(dut.count_r), 64'd0);
    chk("arst_mem_req_val", 64'(mem_req_val), 64'd0);
    chk("arst_src_req_rdy", 64'(src_req_rdy), 64'd0);
    chk("arst_mem_resp_rdy", 64'(mem_resp_rdy), 64'd0);
    chk("arst_src_resp_val", 64'(src_resp_val), 64'd0);
    chk("arst_orphan", 64'(orphan_err), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    resp_drive(1'b0);
    set_req(1, 1'b1, 8'd51, 6'd10); #1;
    chk("arst_rr_ptr", 64'(dut.rr_ptr_r), 64'd0);
    chk("arst_grant0_rdy", 64'(src_req_rdy), 64'b01);
    chk("arst_grant0_flowid", 64'(mem_req_flowid), 64'd50);
    tick();
    set_req(0, 1'b0, 8'd50, 6'd9); #1;
    chk("arst_grant1_rdy", 64'(src_req_rdy), 64'b10);
    tick();
    set_req(1, 1'b0, 8'd51, 6'd10);
    for (int c = 0; c < 2; c++) begin
      resp_drive(1'b1); #1;
      tick();
    end
    resp_drive(1'b0); #1;
    chk("end_count0", 64'(dut.count_r), 64'd0);
    chk("end_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("end_orphan", 64'(orphan_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_buf_rd_arb.md
Name: rx_buf_rd_arb

Overview:
- Round-robin arbiter that shares one read port of the RX payload buffer store among NUM_REQ requesters, for example the app-copy engine and the reassembly/debug readers.
- Accepts flowid+idx read requests and forwards one per cycle to the store's read port.
- Records the grant ID of every forwarded request in an in-order tag FIFO, and routes each returning buffer to the requester that issued it.
- Sits between the requesters and the store's rd0 port; the store returns responses in request order.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TAG_DEPTH, 4, number of read requests that may be outstanding in the store; power of 2.
- REQ_ID_W, $clog2(NUM_REQ), width of a stored grant ID (derived, not overridden).
- FLOWID_W, RX_PAYLOAD_IDX_W, TCP_BUF_W: taken from tcp_pkg, not parameters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- src_req_val  in  NUM_REQ  per-requester read request valid.
- src_req_flowid  in  NUM_REQ*FLOWID_W  flattened flowids; requester i at [i*FLOWID_W +: FLOWID_W].
- src_req_idx  in  NUM_REQ*RX_PAYLOAD_IDX_W  flattened buffer indices.
- src_req_rdy  out  NUM_REQ  request accepted.
- src_resp_val  out  NUM_REQ  response valid, one-hot or zero.
- src_resp_data  out  TCP_BUF_W  response data, shared by all requesters.
- src_resp_rdy  in  NUM_REQ  per-requester response ready.
- mem_req_val  out  1  read request to the store.
- mem_req_flowid  out  FLOWID_W  flowid sent to the store.
- mem_req_idx  out  RX_PAYLOAD_IDX_W  buffer index sent to the store.
- mem_req_rdy  in  1  store accepts the request.
- mem_resp_val  in  1  store response valid.
- mem_resp_data  in  TCP_BUF_W  store response data.
- mem_resp_rdy  out  1  ready back to the store.
- orphan_err  out  1  sticky: a store response arrived with no outstanding tag.

Behaviour:
- Reset (asynchronous): rr_ptr=0, lock_val=0, tag FIFO empty (rd_ptr=wr_ptr=count=0), orphan_err=0.
  - Outputs during reset: all val/rdy outputs 0.
- Handshakes: valid/ready. A transfer occurs when val & rdy are both high on a rising clk. Requesters hold val and payload until rdy.
- Request arbitration (combinational, zero added latency):
  - tag_full = (count == TAG_DEPTH).
  - If lock_val=1, grant = lock_id.
  - Otherwise grant is the first i with src_req_val[i]=1, searching from rr_ptr upward and wrapping mod NUM_REQ.
  - mem_req_val = grant exists & !tag_full. The flowid/idx of the granted requester are muxed onto mem_req_*.
  - src_req_rdy[grant] = mem_req_rdy & !tag_full; every other bit is 0.
- Grant lock (registered): if mem_req_val & !mem_req_rdy, then lock_val<=1 and lock_id<=grant. This keeps mem_req_* stable until acceptance; a newly asserting higher-priority requester cannot change it. Cleared on the request handshake.
- On a request handshake: push grant into the tag FIFO; rr_ptr <= (grant+1) mod NUM_REQ; lock_val<=0.
- tag_full blocks arbitration entirely. The full test uses the registered count, so a same-cycle pop does not unblock a push.
- Response routing (combinational):
  - head = tag FIFO entry at rd_ptr; empty = (count==0).
  - src_resp_val[head] = mem_resp_val & !empty; src_resp_data = mem_resp_data.
  - mem_resp_rdy = src_resp_rdy[head] & !empty.
  - Backpressure from the head requester stalls all responses (in-order, no bypass).
  - On a response handshake: pop the tag FIFO.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap mod TAG_DEPTH.
- Orphan response: mem_resp_val=1 while empty sets orphan_err<=1 until reset. mem_resp_rdy stays 0 and nothing is popped.
- Requester deasserting val while un-granted: allowed. Deasserting while locked: protocol violation, not required to be handled.

Test Plan:
- Single requester: src 1 reads flowid=3, idx=5; store rdy=1 and responds 2 cycles later with data=0xAB -> mem_req_flowid=3, mem_req_idx=5 in the same cycle as the request; src_resp_val=2'b10 with data 0xAB; tag count returns to 0.
- Round-robin fairness: both requesters hold val for 6 cycles, mem_req_rdy=1 -> grants alternate 0,1,0,1,0,1; tag FIFO order matches; responses route to the matching requester.
- Lock under backpressure: src 1 requests, mem_req_rdy=0 for 3 cycles, src 0 asserts in cycle 1 -> mem_req_* stays src 1's request through acceptance; src 0 is granted next.
- Tag full: TAG_DEPTH=4, mem_resp_val=0, 5 requests -> 4 accepted; the 5th sees src_req_rdy=0 until the first response pops; pop and request in the same cycle leave count=4 with no push.
- Response backpressure: head=src 0 with src_resp_rdy[0]=0 for 2 cycles -> mem_resp_rdy=0 and the next tag is not popped; transfer occurs on the cycle rdy rises.
- Orphan and reset: mem_resp_val=1 with an empty FIFO -> orphan_err=1 next cycle and sticky. Asserting rst mid-stream with 2 tags outstanding -> outputs and count are 0 immediately (asynchronous); rr_ptr=0 after release.
